// File: rtl/bcd_display_ctrl_if.sv
// Bus between a value producer and the BCD display controller: load/value in,
// busy/done status and registered digits with blanking flags out.
interface bcd_display_ctrl_if;
  logic [7:0] value;
  logic       load;
  logic       busy;
  logic       done;
  logic [3:0] unidades;
  logic [3:0] decenas;
  logic [3:0] centenas;
  logic       blank_dec;
  logic       blank_cen;
  logic [1:0] state;

  modport master (
    output value, load,
    input  busy, done, unidades, decenas, centenas, blank_dec, blank_cen, state
  );

  modport slave (
    input  value, load,
    output busy, done, unidades, decenas, centenas, blank_dec, blank_cen, state
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-and-add-3) with
// registered digits, leading-zero blanking flags and a load/busy/done handshake.
module bcd_display_ctrl #(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  bcd_display_ctrl_if.slave bus
);

  // Handshake: a request is taken whenever load=1 at a rising edge. In IDLE it
  // starts at once; while busy it is parked in a single pending slot where the
  // newest request overwrites older ones. busy covers active and pending work;
  // done is a one-cycle pulse in the cycle after digits are published.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q;
  logic [11:0]      scratch_q;
  logic [11:0]      scratch_adj;
  logic [2:0]       cnt_q;
  logic             pending_q;
  logic [WIDTH-1:0] pend_val_q;
  logic             start;
  logic [WIDTH-1:0] start_val;
  logic             done_q;
  logic [3:0]       uni_q, dec_q, cen_q;
  logic             blank_dec_q, blank_cen_q;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  assign scratch_adj = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    start_val = bus.value;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          start     = 1'b1;
          start_val = bus.value;
          state_d   = SHIFT;
        end else if (pending_q) begin
          start     = 1'b1;
          start_val = pend_val_q;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == 3'd7) state_d = PUBLISH;
      end
      PUBLISH: begin
        // A request arriving on this very edge is newer than the parked one.
        if (pending_q) begin
          start     = 1'b1;
          start_val = bus.load ? bus.value : pend_val_q;
          state_d   = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      pend_val_q  <= '0;
      done_q      <= 1'b0;
      uni_q       <= '0;
      dec_q       <= '0;
      cen_q       <= '0;
      blank_dec_q <= 1'b1;
      blank_cen_q <= 1'b1;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == PUBLISH);

      if (start) begin
        bin_q     <= start_val;
        scratch_q <= '0;
        cnt_q     <= '0;
      end else if (state_q == SHIFT) begin
        {scratch_q, bin_q} <= {scratch_adj[10:0], bin_q, 1'b0};
        cnt_q              <= cnt_q + 3'd1;
      end

      case (state_q)
        IDLE: begin
          if (start) pending_q <= 1'b0;
        end
        SHIFT: begin
          if (bus.load) begin
            pending_q  <= 1'b1;
            pend_val_q <= bus.value;
          end
        end
        PUBLISH: begin
          if (pending_q) begin
            pending_q <= 1'b0;
          end else if (bus.load) begin
            pending_q  <= 1'b1;
            pend_val_q <= bus.value;
          end
        end
        default: pending_q <= pending_q;
      endcase

      if (state_q == PUBLISH) begin
        cen_q       <= scratch_q[11:8];
        dec_q       <= scratch_q[7:4];
        uni_q       <= scratch_q[3:0];
        blank_cen_q <= (scratch_q[11:8] == 4'd0);
        blank_dec_q <= (scratch_q[11:4] == 8'd0);
      end
    end
  end

  assign bus.busy      = (state_q != IDLE) || pending_q;
  assign bus.done      = done_q;
  assign bus.unidades  = uni_q;
  assign bus.decenas   = dec_q;
  assign bus.centenas  = cen_q;
  assign bus.blank_dec = blank_dec_q;
  assign bus.blank_cen = blank_cen_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Directed self-checking bench for bcd_display_ctrl: reset, full scale, blanking,
// pending requests, abort by reset and a sweep of all 256 input values.
module tb_bcd_display_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  logic [11:0] exp_q[$];

  bcd_display_ctrl_if bus ();

  bcd_display_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] bcd_of(input int v);
    logic [3:0] c, d, u;
    c = 4'(v / 100);
    d = 4'((v / 10) % 10);
    u = 4'(v % 10);
    return {c, d, u};
  endfunction

  function automatic logic [11:0] digits();
    return {bus.centenas, bus.decenas, bus.unidades};
  endfunction

  // Load one value from idle, check busy/hold behaviour, latency and result.
  task automatic do_conv(input int v, input string tag);
    logic [11:0] prev;
    logic [11:0] exp;
    int          n;
    bit          got;
    prev = digits();
    exp_q.push_back(bcd_of(v));
    @(negedge clk);
    bus.value = 8'(v);
    bus.load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
      else if (n < 9) begin
        chk({tag, "_busy_hold"}, 32'(bus.busy), 32'd1);
        chk({tag, "_digits_hold"}, 32'(digits()), 32'(prev));
      end
    end
    chk({tag, "_latency"}, n + 1, 32'd10);
    exp = exp_q.pop_front();
    chk({tag, "_digits"}, 32'(digits()), 32'(exp));
    chk({tag, "_blank_cen"}, 32'(bus.blank_cen), 32'(v < 100));
    chk({tag, "_blank_dec"}, 32'(bus.blank_dec), 32'(v < 10));
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int          dcnt;
    int          dk[2];
    logic [11:0] dv[2];
    bit          gap;
    bit          prev_done;
    bit          back2back;

    tests     = 0;
    fails     = 0;
    rst       = 1'b1;
    bus.load  = 1'b1;
    bus.value = 8'd123;

    // Reset held two cycles with load asserted.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_digits", 32'(digits()), 32'h000);
    chk("rst_blank_cen", 32'(bus.blank_cen), 32'd1);
    chk("rst_blank_dec", 32'(bus.blank_dec), 32'd1);
    rst      = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("post_rst_idle_busy", 32'(bus.busy), 32'd0);
    chk("post_rst_idle_state", 32'(bus.state), 32'd0);

    // Full scale, with done lasting exactly one cycle.
    do_conv(255, "full");
    chk("full_cen", 32'(bus.centenas), 32'd2);
    @(posedge clk);
    @(negedge clk);
    chk("full_done_single", 32'(bus.done), 32'd0);

    // Blanking cases.
    do_conv(7, "blank7");
    do_conv(40, "blank40");
    do_conv(100, "blank100");

    // Pending: 42 at E0, 131 before E3, 199 before E5; 199 must win.
    @(negedge clk);
    bus.value = 8'd42;
    bus.load  = 1'b1;
    @(posedge clk);
    dcnt      = 0;
    gap       = 1'b0;
    prev_done = 1'b0;
    back2back = 1'b0;
    dk[0] = 0; dk[1] = 0; dv[0] = '0; dv[1] = '0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (k == 3) begin
        bus.value = 8'd131;
        bus.load  = 1'b1;
      end else if (k == 5) begin
        bus.value = 8'd199;
        bus.load  = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (dcnt < 2) begin
          dk[dcnt] = k;
          dv[dcnt] = digits();
        end
        dcnt++;
        if (prev_done) back2back = 1'b1;
      end
      prev_done = bus.done;
      if (k < 18 && !bus.busy) gap = 1'b1;
    end
    chk("pend_done_count", dcnt, 32'd2);
    chk("pend_first_edge", dk[0], 32'd9);
    chk("pend_first_val", 32'(dv[0]), 32'h042);
    chk("pend_second_edge", dk[1], 32'd18);
    chk("pend_second_val", 32'(dv[1]), 32'h199);
    chk("pend_busy_gap", 32'(gap), 32'd0);
    chk("pend_done_b2b", 32'(back2back), 32'd0);
    chk("pend_busy_end", 32'(bus.busy), 32'd0);

    // Abort: reset during the fourth SHIFT cycle of a conversion of 200.
    @(negedge clk);
    bus.value = 8'd200;
    bus.load  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_digits", 32'(digits()), 32'h000);
    chk("abort_blank_cen", 32'(bus.blank_cen), 32'd1);
    chk("abort_blank_dec", 32'(bus.blank_dec), 32'd1);
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort_no_done", dcnt, 32'd0);
    chk("abort_digits_later", 32'(digits()), 32'h000);

    // Sweep of every input value.
    for (int v = 0; v < 256; v++) do_conv(v, "sweep");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_display_ctrl.md
Name: bcd_display_ctrl

Overview:
Sequential controller that converts an 8-bit binary value into three BCD digits (hundreds, tens, units) using an iterative shift-and-add-3 (double dabble) sequence. It drives the per-digit `segmentos_7` decoders (HEX2/HEX1/HEX0) from registered digits. It replaces per-digit divide/modulo logic with an 8-cycle sequenced conversion and a load/busy/done handshake. It also provides leading-zero blanking flags for the display wrapper.

Parameters:
- WIDTH, 8, binary input width; this revision supports only 8. Fixed: 3 BCD digits, 8 shift iterations.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  8  binary value to convert; sampled only when a load is accepted.
- load  input  1  conversion request strobe, sampled on each rising edge.
- busy  output  1  high while a conversion is in progress or pending.
- done  output  1  one-cycle pulse when new digits are published.
- unidades  output  4  registered units digit, 0..9.
- decenas  output  4  registered tens digit, 0..9.
- centenas  output  4  registered hundreds digit, 0..2.
- blank_dec  output  1  registered; tens display blanked (centenas==0 and decenas==0).
- blank_cen  output  1  registered; hundreds display blanked (centenas==0).

Behaviour:
Clock and reset:
- One clock domain (clk); reset is synchronous and active-high (rst).
- On any edge with rst=1: state=IDLE; shift/scratch registers, iteration counter, pending flag and pending value cleared.
- Reset values of outputs: busy=0, done=0, unidades=decenas=centenas=0, blank_dec=1, blank_cen=1.
- rst overrides load and aborts any conversion. No partial result is ever published.

State machine (IDLE, SHIFT, PUBLISH):
- IDLE, load=1 at edge E0:
  - Capture value into the 8-bit binary shift register; clear the 12-bit BCD scratch; counter=0.
  - Go to SHIFT; busy=1 after E0.
- IDLE, load=0: hold. Outputs keep their last published values.
- SHIFT, each edge E1..E8:
  - For each scratch nibble >= 5, add 3 (4-bit add, no carry across nibbles).
  - Then shift {scratch, binary} left by 1, so the binary MSB enters the scratch LSB.
  - counter increments. On the edge where counter==7 (E8), go to PUBLISH.
- PUBLISH, edge E9:
  - Copy the scratch nibbles to centenas/decenas/unidades and compute both blank flags from the new digits, in the same edge.
  - done=1 for exactly the cycle after E9.
  - If pending=0: go to IDLE; busy=0 after E9.
  - If pending=1: behave as IDLE+load using the pending value (start a new conversion at E9 with counter reset); clear pending; busy stays 1.
- Latency: load edge to digits visible is 9 edges. Back-to-back throughput is one conversion per 9 cycles.

Loads while busy:
- load=1 in SHIFT or PUBLISH: set pending=1 and latch value into the pending register. The last request wins; earlier pending values are overwritten. There is no error flag.
- load=1 on the PUBLISH edge itself: also captured as pending. It is honoured at that same edge if pending was already set (new pending value used), else at the next IDLE edge via pending.
  - Implementation detail: PUBLISH→IDLE with pending set starts at the next edge. Either is acceptable as long as no request is lost and done pulses once per publish.

Invariants:
- Digits and blank flags never change except at a PUBLISH edge or at reset.
- Published digits are each <= 9, and centenas <= 2.
- done never asserts on two consecutive cycles. A back-to-back conversion forces at least 8 cycles between pulses.

Test Plan:
- Reset: hold rst 2 cycles with load=1 → busy=0, done=0, digits 0/0/0, blank_cen=1, blank_dec=1. No conversion starts after rst drops, since load was held only during reset.
- Full scale: value=255, load pulsed 1 cycle → busy high for 9 cycles; done pulse 9 edges after load; centenas=2, decenas=5, unidades=5; blank_cen=0, blank_dec=0.
- Blanking: value=7 → 0/0/7 with blank_cen=1, blank_dec=1. Then value=40 → 0/4/0 with blank_cen=1, blank_dec=0. Then value=100 → 1/0/0 with both flags 0.
- Pending: load 42, then load 131 at cycle 3 and 199 at cycle 5 → first done publishes 0/4/2. A second conversion follows without an idle gap, with busy continuously high, and publishes 1/9/9. Exactly two done pulses.
- Abort: load 200, assert rst at cycle 4 of SHIFT → outputs return to reset values; no done pulse; no later publish of 200.
- Exhaustive sweep: values 0..255, each loaded after done → every published triple equals value/100, (value/10)%10, value%10, and each blank flag matches its definition.
